// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU bus sequencer.
// Holds the sequencer state encoding, the decoder lane-mask constants
// and a word-alignment helper used when driving the data address.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_cpu_bus_align.sv
// Combinational lane steering for data-memory accesses.
// Ports:
//   offset_i  - byte offset within the word (data address bits [1:0])
//   be_i      - decoder lane mask, right-justified (0001/0011/1111)
//   wdata_i   - store data, right-justified (rt register value)
//   be_o      - lane mask moved to the addressed byte lanes, upper lanes dropped
//   wdata_o   - store data moved to the addressed byte lanes
module mips_cpu_bus_align (
    input  logic [1:0]  offset_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        // Shift result keeps the left operand width, so lanes past byte 3 fall off.
        be_o    = be_i << offset_i;
        wdata_o = wdata_i << {offset_i, 3'b000};
    end

endmodule

// File: rtl/mips_cpu_bus_sequencer.sv
// Multi-cycle bus sequencer for a MIPS CPU: fetches an instruction over a
// single Avalon-style bus, performs at most one data access, and produces
// the commit pulse and register-write qualifier for the rest of the core.
// Ports:
//   clk_i, rst_n_i        - clock, asynchronous active-low reset
//   clk_enable_i          - global stall; low freezes all state
//   pc_addr_i, pc_next_i  - fetch address / next PC (checked at commit for halt)
//   data_read_i/_write_i  - decoder memory-op request
//   byte_enable_i         - decoder lane mask
//   data_addr_i, data_wdata_i - ALU address and store data
//   bus_*                 - memory bus master (address/read/write/be/wdata, readdata/waitrequest)
//   instr_readdata_o      - latched instruction word
//   mem_rdata_o           - latched load word
//   reg_write_gate_o      - qualifies the decoder register write
//   pc_update_o           - one-cycle commit pulse
//   active_o              - high from first fetch until halted
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | out of reset, bus quiet, start fetching next enabled cycle
// ST_FETCH  | instruction read on the bus, wait for waitrequest low
// ST_EXEC   | one decode cycle; commit here if no memory operation
// ST_MEM    | data read or write on the bus, wait for waitrequest low
// ST_WB     | load data available; commit with register write
// ST_HALTED | committed with next PC of zero; terminal until reset
module mips_cpu_bus_sequencer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clk_enable_i,
    input  logic [31:0] pc_addr_i,
    input  logic [31:0] pc_next_i,
    input  logic        data_read_i,
    input  logic        data_write_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] bus_address_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    output logic [3:0]  bus_byteenable_o,
    output logic [31:0] bus_writedata_o,
    input  logic [31:0] bus_readdata_i,
    input  logic        bus_waitrequest_i,
    output logic [31:0] instr_readdata_o,
    output logic [31:0] mem_rdata_o,
    output logic        reg_write_gate_o,
    output logic        pc_update_o,
    output logic        active_o
);
    import mips_cpu_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_op;
    logic        commit;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;

    assign mem_op = data_read_i | data_write_i;

    mips_cpu_bus_align u_align (
        .offset_i (data_addr_i[1:0]),
        .be_i     (byte_enable_i),
        .wdata_i  (data_wdata_i),
        .be_o     (align_be),
        .wdata_o  (align_wdata)
    );

    // Bus strobes are decoded from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        state_d          = state_q;
        instr_d          = instr_q;
        mem_rdata_d      = mem_rdata_q;
        bus_address_o    = '0;
        bus_read_o       = 1'b0;
        bus_write_o      = 1'b0;
        bus_byteenable_o = BE_NONE;
        bus_writedata_o  = '0;
        commit           = 1'b0;
        reg_write_gate_o = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                bus_read_o       = 1'b1;
                bus_address_o    = pc_addr_i;
                bus_byteenable_o = BE_WORD;
                if (!bus_waitrequest_i) begin
                    instr_d = bus_readdata_i;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (mem_op) begin
                    state_d = ST_MEM;
                end else begin
                    commit           = 1'b1;
                    reg_write_gate_o = 1'b1;
                end
            end
            ST_MEM: begin
                bus_address_o    = word_align(data_addr_i);
                bus_byteenable_o = align_be;
                // A write wins over a simultaneous read request.
                if (data_write_i) begin
                    bus_write_o     = 1'b1;
                    bus_writedata_o = align_wdata;
                    if (!bus_waitrequest_i) begin
                        commit = 1'b1;
                    end
                end else begin
                    bus_read_o = 1'b1;
                    if (!bus_waitrequest_i) begin
                        mem_rdata_d = bus_readdata_i;
                        state_d     = ST_WB;
                    end
                end
            end
            ST_WB: begin
                commit           = 1'b1;
                reg_write_gate_o = 1'b1;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

        if (commit) begin
            state_d = (pc_next_i == 32'd0) ? ST_HALTED : ST_FETCH;
        end

        // Stall: nothing moves and no commit side effects leak out.
        if (!clk_enable_i) begin
            state_d          = state_q;
            instr_d          = instr_q;
            mem_rdata_d      = mem_rdata_q;
            commit           = 1'b0;
            reg_write_gate_o = 1'b0;
        end

        pc_update_o = commit;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign instr_readdata_o = instr_q;
    assign mem_rdata_o      = mem_rdata_q;
    assign active_o         = (state_q != ST_IDLE) && (state_q != ST_HALTED);

endmodule

// File: tb/tb_mips_cpu_bus_sequencer.sv
module tb_mips_cpu_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [31:0] pc_addr, pc_next, data_addr, data_wdata;
    logic        data_read, data_write;
    logic [3:0]  byte_enable;
    logic [31:0] bus_address, bus_writedata, bus_readdata;
    logic        bus_read, bus_write, waitreq;
    logic [3:0]  bus_be;
    logic [31:0] instr_rd, mem_rd;
    logic        gate, pc_update, active;

    always #5 clk = ~clk;

    mips_cpu_bus_sequencer dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .clk_enable_i      (clk_en),
        .pc_addr_i         (pc_addr),
        .pc_next_i         (pc_next),
        .data_read_i       (data_read),
        .data_write_i      (data_write),
        .byte_enable_i     (byte_enable),
        .data_addr_i       (data_addr),
        .data_wdata_i      (data_wdata),
        .bus_address_o     (bus_address),
        .bus_read_o        (bus_read),
        .bus_write_o       (bus_write),
        .bus_byteenable_o  (bus_be),
        .bus_writedata_o   (bus_writedata),
        .bus_readdata_i    (bus_readdata),
        .bus_waitrequest_i (waitreq),
        .instr_readdata_o  (instr_rd),
        .mem_rdata_o       (mem_rd),
        .reg_write_gate_o  (gate),
        .pc_update_o       (pc_update),
        .active_o          (active)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        gate;
        logic [31:0] instr;
        logic        chk_mem;
        logic [31:0] mem;
        int          base;
    } cmt_exp_t;

    bus_exp_t bus_q[$];
    cmt_exp_t cmt_q[$];

    int vectors = 0;
    int miscompares = 0;
    int commits = 0;
    int cyc = 0;
    int waits_acc = 0;
    int wait_ovr = -1;
    int stall_mode = 0;
    logic hold_wait = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a ^ 32'hA5A5_0F0F) + {a[15:0], a[31:16]};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: what the bus and commit interface must show for one instruction.
    // kind: 0 = no memory op, 1 = load, 2 = store, 3 = read+write (store wins)
    task automatic issue(input logic [31:0] pc, input logic [31:0] pcn, input int kind,
                         input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
        bus_exp_t    b;
        cmt_exp_t    c;
        int          off;
        logic [63:0] prod;
        pc_addr     = pc;
        pc_next     = pcn;
        data_read   = (kind == 1 || kind == 3);
        data_write  = (kind >= 2);
        byte_enable = be;
        data_addr   = da;
        data_wdata  = wd;
        b.we = 1'b0; b.addr = pc; b.be = 4'hF; b.wdata = 32'h0;
        bus_q.push_back(b);
        off = int'(da % 4);
        if (kind != 0) begin
            b.we    = (kind >= 2);
            b.addr  = da - 32'(off);
            b.be    = 4'((int'(be) * (1 << off)) % 16);
            prod    = 64'(wd) * (64'd1 << (8 * off));
            b.wdata = prod[31:0];
            bus_q.push_back(b);
        end
        c.gate    = (kind == 0 || kind == 1);
        c.instr   = mem_fn(pc);
        c.chk_mem = (kind == 1);
        c.mem     = mem_fn(da - 32'(off));
        c.base    = (kind == 0) ? 2 : ((kind == 1) ? 4 : 3);
        cmt_q.push_back(c);
    endtask

    task automatic wait_commit(input string name);
        int start = commits;
        int n = 0;
        while (commits == start && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (commits == start) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no commit expected commit within 400 cycles", name);
        end
        #2;
    endtask

    // Stall generator.
    initial begin
        clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_mode == 1)      clk_en = ($urandom_range(0, 5) != 0);
            else if (stall_mode == 2) clk_en = 1'b0;
            else                      clk_en = 1'b1;
        end
    end

    // Memory slave: random waits, readdata is a fixed function of the address.
    initial begin
        logic busy = 1'b0;
        int   wleft = 0;
        waitreq = 1'b0;
        bus_readdata = '0;
        forever begin
            @(negedge clk);
            bus_readdata = mem_fn(bus_address);
            if (!rst_n) begin
                busy = 1'b0;
                waitreq = 1'b0;
            end else if (clk_en) begin
                if (bus_read || bus_write) begin
                    if (!busy) begin
                        busy = 1'b1;
                        if (hold_wait)         wleft = 100000;
                        else if (wait_ovr >= 0) wleft = wait_ovr;
                        else                    wleft = $urandom_range(0, 3);
                    end
                    if (wleft > 0) begin
                        waitreq = 1'b1;
                        wleft--;
                        waits_acc++;
                    end else begin
                        waitreq = 1'b0;
                        busy = 1'b0;
                    end
                end else begin
                    waitreq = 1'b0;
                    busy = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        bus_exp_t e;
        cmt_exp_t c;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (bus_read && bus_write) chk("rd_wr_exclusive", 32'(bus_read & bus_write), 32'd0);
                if (clk_en) begin
                    if (active) cyc++;
                    if ((bus_read || bus_write) && !waitreq) begin
                        if (bus_q.size() == 0) begin
                            chk("unexpected_xfer", {bus_read, bus_write}, 32'd0);
                        end else begin
                            e = bus_q.pop_front();
                            chk("xfer_write", 32'(bus_write), 32'(e.we));
                            chk("xfer_read", 32'(bus_read), 32'(!e.we));
                            chk("xfer_addr", bus_address, e.addr);
                            chk("xfer_be", 32'(bus_be), 32'(e.be));
                            if (e.we) chk("xfer_wdata", bus_writedata, e.wdata);
                        end
                    end
                    if (pc_update) begin
                        if (cmt_q.size() == 0) begin
                            chk("unexpected_commit", 32'(pc_update), 32'd0);
                        end else begin
                            c = cmt_q.pop_front();
                            chk("commit_gate", 32'(gate), 32'(c.gate));
                            chk("instr_readdata", instr_rd, c.instr);
                            if (c.chk_mem) chk("mem_rdata", mem_rd, c.mem);
                            chk("latency", cyc, c.base + waits_acc);
                        end
                        commits++;
                        cyc = 0;
                        waits_acc = 0;
                    end
                end else begin
                    chk("stall_gates", {pc_update, gate}, 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end expected end before 1 ms");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_addr;
        logic [31:0] pc;
        int n;
        rst_n = 1'b0;
        pc_addr = '0; pc_next = '0; data_addr = '0; data_wdata = '0;
        data_read = 1'b0; data_write = 1'b0; byte_enable = 4'h0;

        // Reset values.
        #3;
        chk("rst_read", 32'(bus_read), 32'd0);
        chk("rst_write", 32'(bus_write), 32'd0);
        chk("rst_addr", bus_address, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_wdata", bus_writedata, 32'd0);
        chk("rst_instr", instr_rd, 32'd0);
        chk("rst_mem", mem_rd, 32'd0);
        chk("rst_pulses", {pc_update, gate}, 32'd0);
        chk("rst_active", 32'(active), 32'd0);

        // Reset during a stalled fetch drops the read at once.
        hold_wait = 1'b1;
        pc_addr = 32'hBFC0_0000;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        chk("fetch_held_read", 32'(bus_read), 32'd1);
        chk("fetch_held_addr", bus_address, 32'hBFC0_0000);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_read", 32'(bus_read), 32'd0);
        chk("rst_drop_addr", bus_address, 32'd0);
        repeat (2) @(posedge clk);
        hold_wait = 1'b0;
        cyc = 0;
        waits_acc = 0;

        // ADDIU from the reset vector, no waits: commit in the third cycle.
        wait_ovr = 0;
        issue(32'hBFC0_0000, 32'hBFC0_0004, 0, 4'b1111, 32'h0, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("idle_after_rst", {active, bus_read}, 32'd0);
        wait_commit("addiu");

        // LW 0x1004 with three waits on every transfer.
        wait_ovr = 3;
        issue(32'hBFC0_0004, 32'hBFC0_0008, 1, 4'b1111, 32'h0000_1004, 32'h0);
        wait_commit("lw");

        // SB to the top byte lane.
        wait_ovr = 0;
        issue(32'hBFC0_0008, 32'hBFC0_000C, 2, 4'b0001, 32'h0000_1003, 32'h0000_00AB);
        wait_commit("sb");

        // Stall for five cycles in the middle of a load.
        wait_ovr = 2;
        issue(32'hBFC0_000C, 32'hBFC0_0010, 1, 4'b0011, 32'h0000_2008, 32'h0);
        n = 0;
        while (!(bus_read && bus_address == 32'h0000_2008) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mem_reached", 32'(bus_read && bus_address == 32'h0000_2008), 32'd1);
        stall_mode = 2;
        @(posedge clk); #2;
        held_addr = bus_address;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_read", 32'(bus_read), 32'd1);
            chk("stall_addr", bus_address, held_addr);
            chk("stall_be", 32'(bus_be), 32'h3);
        end
        stall_mode = 0;
        wait_commit("stall_lw");

        // Randomized instruction stream with random waits and stalls.
        wait_ovr = -1;
        stall_mode = 1;
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  be;
            logic [31:0] pcn;
            int          sel;
            pc  = $urandom & 32'hFFFF_FFFC;
            pcn = $urandom & 32'hFFFF_FFFC;
            if (pcn == 32'd0) pcn = 32'd4;
            sel = $urandom_range(0, 2);
            be  = (sel == 0) ? 4'b0001 : ((sel == 1) ? 4'b0011 : 4'b1111);
            issue(pc, pcn, $urandom_range(0, 3), be, $urandom, $urandom);
            wait_commit("random");
        end

        // JR with a zero next PC halts the sequencer.
        stall_mode = 0;
        issue(32'hBFC0_0100, 32'h0, 0, 4'b1111, 32'h0, 32'h0);
        wait_commit("jr_halt");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("halted_quiet", {active, bus_read, bus_write}, 32'd0);
        end

        chk("bus_queue_drained", bus_q.size(), 32'd0);
        chk("commit_queue_drained", cmt_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_sequencer.md
MIPS_CPU_BUS_SEQUENCER -- requirements
Module: mips_cpu_bus_sequencer

Interface
REQ-001 SHALL provide clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL provide reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL provide clk_enable, input, 1, global stall; low freezes state and all registered outputs.
REQ-004 SHALL provide pc_addr, input, 32, fetch address from PC unit.
REQ-005 SHALL provide pc_next, input, 32, next PC from PC unit, sampled at commit.
REQ-006 SHALL provide data_read / data_write, input, 1 each, from decoder.
REQ-007 SHALL provide byte_enable, input, 4, decoder lane mask (0001 byte, 0011 half, 1111 word).
REQ-008 SHALL provide data_addr / data_wdata, input, 32 each, ALU address and rt store data.
REQ-009 SHALL provide bus ports: address out 32, read out 1, write out 1, byteenable out 4, writedata out 32, readdata in 32, waitrequest in 1.
REQ-010 SHALL provide instr_readdata, output, 32, latched instruction for decoder.
REQ-011 SHALL provide mem_rdata, output, 32, latched load word for writeback.
REQ-012 SHALL provide reg_write_gate, output, 1, qualifies decoder reg_write_enable.
REQ-013 SHALL provide pc_update, output, 1, one-cycle commit pulse enabling PC load.
REQ-014 SHALL provide active, output, 1, high from first FETCH until HALTED.

Function
REQ-015 SHALL implement states IDLE, FETCH, EXEC, MEM, WB, HALTED.
REQ-016 IDLE: all bus strobes low; next enabled cycle -> FETCH, active rises.
REQ-017 FETCH: read=1, address=pc_addr, byteenable=1111; hold while waitrequest=1; on waitrequest=0 latch readdata into instr_readdata, -> EXEC.
REQ-018 EXEC: exactly one cycle; no memory op -> reg_write_gate=1, pc_update=1, -> FETCH; memory op -> MEM with no gate/pulse.
REQ-019 MEM: address={data_addr[31:2],2'b00}, byteenable=(byte_enable << data_addr[1:0]) truncated to 4 bits, writedata=data_wdata << 8*data_addr[1:0]; hold while waitrequest=1.
REQ-020 MEM read accept: latch readdata into mem_rdata, -> WB; write accept: pc_update=1, -> FETCH.
REQ-021 WB: reg_write_gate=1, pc_update=1, one cycle, -> FETCH.
REQ-022 data_read and data_write both high: write performed, read suppressed.
REQ-023 Commit (pc_update=1) with pc_next==0: next state HALTED instead of FETCH.
REQ-024 HALTED: strobes low, active=0, terminal until reset.
REQ-025 read and write SHALL never be high together; address/byteenable/writedata stable while waitrequest=1.
REQ-026 clk_enable=0 in any state: no transition, no latch, strobes held; pc_update/reg_write_gate forced 0.
REQ-027 Latency: non-memory instruction = fetch wait + 2 cycles; load = fetch + mem waits + 4 cycles.

Reset
REQ-028 Reset asserted: state=IDLE, read=write=0, address=0, byteenable=0, writedata=0, instr_readdata=0, mem_rdata=0, pc_update=0, reg_write_gate=0, active=0.
REQ-029 Reset mid-transaction SHALL drop strobes immediately (asynchronous); no partial commit.

Structure
REQ-030 State enum and byte-enable constants SHALL reside in shared package mips_cpu_pkg.
REQ-031 Lane shifting of byteenable/writedata SHALL be sub-module mips_cpu_bus_align (combinational).

Verification
REQ-032 ADDIU at pc_addr=0xBFC00000, waitrequest=0 -> FETCH, EXEC; pc_update and reg_write_gate high in cycle 3.
REQ-033 LW, data_addr=0x1004, waitrequest high 3 cycles in MEM -> read held 4 cycles at 0x1004, mem_rdata=readdata, WB gate.
REQ-034 SB, data_addr=0x1003, data_wdata=0xAB -> byteenable=1000, writedata=0xAB000000, write 1 cycle.
REQ-035 JR commit with pc_next=0 -> HALTED, active=0, no further bus reads.
REQ-036 reset driven low during FETCH with waitrequest=1 -> read drops same cycle, IDLE after release.
REQ-037 clk_enable=0 for 5 cycles in MEM -> state, strobes, address unchanged; completes after re-enable.
